// File: rtl/sample_stream_buffer_if.sv
// Sample stream buffer bus: capture-side controls, read-side handshake and status.
interface sample_stream_buffer_if #(
  parameter int SAMPLE_WIDTH = 10,
  parameter int FIFO_DEPTH   = 32768
);
  localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1;

  logic                    collectData;
  logic                    sampleValid;
  logic [SAMPLE_WIDTH-1:0] sampleIn;
  logic [1:0]              testMode;
  logic                    dcOffsetEnable;
  logic [SAMPLE_WIDTH-1:0] dcOffset;
  logic                    readData;
  logic [15:0]             dataOut;
  logic                    dataAvailable;
  logic                    bufferError;
  logic [15:0]             dropCount;
  logic [LEVEL_WIDTH-1:0]  fifoLevel;

  modport master (
    output collectData, sampleValid, sampleIn, testMode, dcOffsetEnable, dcOffset, readData,
    input  dataOut, dataAvailable, bufferError, dropCount, fifoLevel
  );

  modport slave (
    input  collectData, sampleValid, sampleIn, testMode, dcOffsetEnable, dcOffset, readData,
    output dataOut, dataAvailable, bufferError, dropCount, fifoLevel
  );
endinterface

// File: rtl/sample_stream_buffer.sv
// ADC / test-pattern sample path with DC-offset correction, signed conversion
// and a FIFO toward the FX3 GPIF read side, plus packet and error status.
module sample_stream_buffer #(
  parameter int SAMPLE_WIDTH = 10,
  parameter int FIFO_DEPTH   = 32768,
  parameter int PACKET_WORDS = 8192,
  parameter int GUARD_WORDS  = 64
) (
  input logic fx3_clock,
  input logic nReset,
  sample_stream_buffer_if.slave bus
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int SHIFT = 16 - SAMPLE_WIDTH;
  localparam logic [LW-1:0] PACKET_LVL = LW'(PACKET_WORDS);
  localparam logic [LW-1:0] GUARD_LVL  = LW'(FIFO_DEPTH - GUARD_WORDS);
  localparam logic [SAMPLE_WIDTH-1:0] MID_SCALE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic                    collectReg;
  logic                    startPulse;
  logic                    accept;
  logic [SAMPLE_WIDTH-1:0] patternCount;
  logic                    altPhase;
  logic [SAMPLE_WIDTH-1:0] srcSample;
  logic                    s1Valid;
  logic [SAMPLE_WIDTH-1:0] s1Data;
  logic [SAMPLE_WIDTH-1:0] s1Signed;
  logic [15:0]             converted;
  logic                    s2Valid;
  logic [15:0]             s2Data;
  logic [15:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]           wrPtr;
  logic [AW-1:0]           rdPtr;
  logic [LW-1:0]           level;
  logic [LW-1:0]           levelNext;
  logic                    full;
  logic                    popEn;
  logic                    pushEn;
  logic                    dropNow;
  logic                    underflow;
  logic [15:0]             dataOutReg;
  logic                    availReg;
  logic                    errorReg;
  logic [15:0]             dropReg;

  assign startPulse = bus.collectData && !collectReg;
  assign accept     = bus.collectData && collectReg && bus.sampleValid;
  assign full       = level[LW-1];
  assign popEn      = !startPulse && bus.readData && (level != '0);
  assign pushEn     = !startPulse && s2Valid && (!full || popEn);
  assign dropNow    = !startPulse && s2Valid && full && !popEn;
  assign underflow  = bus.readData && (level == '0);

  // Flipping the MSB of an offset-binary sample gives its two's-complement value.
  assign s1Signed  = {~s1Data[SAMPLE_WIDTH-1], s1Data[SAMPLE_WIDTH-2:0]};
  assign converted = 16'(s1Signed) << SHIFT;

  assign bus.dataOut       = dataOutReg;
  assign bus.dataAvailable = availReg;
  assign bus.bufferError   = errorReg;
  assign bus.dropCount     = dropReg;
  assign bus.fifoLevel     = level;

  // Remember last cycle's capture enable so a rising edge can restart the stream.
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) collectReg <= 1'b0;
    else         collectReg <= bus.collectData;
  end

  // Choose the stage-1 source: offset-corrected ADC or one of the test patterns.
  always_comb begin
    srcSample = bus.sampleIn;
    case (bus.testMode)
      2'd0: begin
        if (bus.dcOffsetEnable)
          srcSample = (bus.sampleIn > bus.dcOffset) ? bus.sampleIn - bus.dcOffset : '0;
      end
      2'd1: srcSample = patternCount;
      2'd2: srcSample = altPhase ? '1 : '0;
      default: srcSample = MID_SCALE;
    endcase
  end

  // Pattern generators advance only on samples accepted in their own mode.
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      patternCount <= '0;
      altPhase     <= 1'b0;
    end else if (startPulse) begin
      patternCount <= '0;
      altPhase     <= 1'b0;
    end else if (accept) begin
      if (bus.testMode == 2'd1) patternCount <= patternCount + SAMPLE_WIDTH'(1);
      if (bus.testMode == 2'd2) altPhase <= ~altPhase;
    end
  end

  // Two-stage pipeline: source select, then signed 16-bit conversion.
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      s1Valid <= 1'b0;
      s1Data  <= '0;
      s2Valid <= 1'b0;
      s2Data  <= '0;
    end else if (startPulse) begin
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
    end else begin
      s1Valid <= accept;
      if (accept) s1Data <= srcSample;
      s2Valid <= s1Valid;
      if (s1Valid) s2Data <= converted;
    end
  end

  // Sample storage; a full FIFO can still take a word when the same cycle pops.
  always_ff @(posedge fx3_clock) begin
    if (pushEn) mem[wrPtr] <= s2Data;
  end

  // Occupancy after this cycle's push and pop.
  always_comb begin
    levelNext = level;
    if (pushEn && !popEn)      levelNext = level + LW'(1);
    else if (popEn && !pushEn) levelNext = level - LW'(1);
  end

  // Pointers, registered level and packet-ready flag; a restart empties the FIFO.
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      availReg <= 1'b0;
    end else if (startPulse) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      availReg <= 1'b0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + AW'(1);
      if (popEn)  rdPtr <= rdPtr + AW'(1);
      level    <= levelNext;
      availReg <= (levelNext >= PACKET_LVL);
    end
  end

  // Registered read port: dataOut holds unless a word is actually popped.
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset)    dataOutReg <= '0;
    else if (popEn) dataOutReg <= mem[rdPtr];
  end

  // Saturating count of words lost to a full FIFO.
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset)                          dropReg <= '0;
    else if (startPulse)                  dropReg <= '0;
    else if (dropNow && dropReg != '1)    dropReg <= dropReg + 16'd1;
  end

  // Sticky error while capturing; released as soon as capture stops.
  always_ff @(posedge fx3_clock or negedge nReset) begin
    if (!nReset)                   errorReg <= 1'b0;
    else if (!bus.collectData)     errorReg <= 1'b0;
    else if (startPulse)           errorReg <= 1'b0;
    else if (dropNow || underflow || (levelNext > GUARD_LVL)) errorReg <= 1'b1;
  end
endmodule
